spi_slave_sync: RTL and testbench

// - SPI responder (slave) end of the SPI link driven by our SPI master; receives MOSI, returns MISO.
// - Fully synchronous to i_sys_clk: SCK/SS_n/MOSI are synchronised and edge-detected, with no pin-clocked flops.
// - Sits between the pad ring and the host register interface; one byte-wide TX holding buffer and one RX buffer.

---
 rtl/spi_slave_sync.sv | 261 ++++++++++++++++++++++++++
 tb/tb_spi_slave_sync.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_sync.sv
// spi_slave_sync: SPI responder running entirely on i_sys_clk.
// SCK, SS_n and MOSI are synchronised and edge-detected; there are no pin-clocked flops.
// Holds one TX holding buffer and one RX buffer between the pads and the host registers.
// Optional receive-overrun flag (o_ovr / i_ovr_clr) is built when SPI_SLV_OVR_EN is defined.
module spi_slave_sync #(
  parameter int unsigned       DATA_W      = 8,
  parameter int unsigned       SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] DEF_TX      = DATA_W'(8'hFF)
) (
  input  logic              i_sys_clk,
  input  logic              i_sys_rst,
  input  logic              i_spe,
  input  logic              i_cpol,
  input  logic              i_cpha,
  input  logic              i_lsbfe,
  input  logic [DATA_W-1:0] i_tx_data,
  input  logic              i_tx_valid,
  output logic              o_tx_ready,
  output logic [DATA_W-1:0] o_rx_data,
  output logic              o_rx_valid,
  input  logic              i_rx_ack,
  output logic              o_busy,
`ifdef SPI_SLV_OVR_EN
  output logic              o_ovr,
  input  logic              i_ovr_clr,
`endif
  input  logic              i_sck,
  input  logic              i_ss_n,
  input  logic              i_mosi,
  output logic              o_miso,
  output logic              o_miso_oe
);

  localparam int unsigned CNT_W = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] ss_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sck_prev;
  logic                   ss_prev;

  logic sck_s;
  logic ss_s;
  logic mosi_s;
  logic sck_rise;
  logic sck_fall;
  logic ss_fall;
  logic lead_edge;
  logic trail_edge;
  logic sample_edge;
  logic shift_edge;
  logic abort;
  logic last_bit;

  logic              cpol_q;
  logic              cpha_q;
  logic              lsbfe_q;
  logic [DATA_W-1:0] tx_hold;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic [DATA_W-1:0] load_src;
  logic [CNT_W-1:0]  bit_cnt;

  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign ss_s   = ss_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign sck_rise = sck_s & ~sck_prev;
  assign sck_fall = ~sck_s & sck_prev;
  assign ss_fall  = ~ss_s & ss_prev;

  // Leading edge leaves the idle level latched at frame load
  assign lead_edge   = cpol_q ? sck_fall : sck_rise;
  assign trail_edge  = cpol_q ? sck_rise : sck_fall;
  assign sample_edge = cpha_q ? trail_edge : lead_edge;
  assign shift_edge  = cpha_q ? lead_edge : trail_edge;

  assign abort    = ~i_spe | ss_s;
  assign last_bit = (bit_cnt == CNT_W'(DATA_W - 1));

  // An empty holding buffer at load time returns the underrun pattern
  assign load_src = o_tx_ready ? DEF_TX : tx_hold;

  // Pin synchronisers; SS_n resets low so a select held across reset is not seen as a new fall
  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      sck_sync  <= '0;
      ss_sync   <= '0;
      mosi_sync <= '0;
      sck_prev  <= 1'b0;
      ss_prev   <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], i_sck};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], i_ss_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_mosi};
      sck_prev  <= sck_s;
      ss_prev   <= ss_s;
    end
  end

  // State register
  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (ss_fall && i_spe) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (sample_edge && last_bit) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = abort ? ST_IDLE : ST_LOAD;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // TX holding buffer: emptied by frame load, filled by an accepted host write
  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      tx_hold    <= '0;
      o_tx_ready <= 1'b1;
    end else if ((state_q == ST_LOAD) && !o_tx_ready) begin
      o_tx_ready <= 1'b1;
    end else if (i_tx_valid && o_tx_ready) begin
      tx_hold    <= i_tx_data;
      o_tx_ready <= 1'b0;
    end
  end

  // Frame datapath: config latch, shift registers, bit count and MISO drive
  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      lsbfe_q   <= 1'b0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      bit_cnt   <= '0;
      o_miso    <= 1'b0;
      o_miso_oe <= 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          cpol_q    <= i_cpol;
          cpha_q    <= i_cpha;
          lsbfe_q   <= i_lsbfe;
          tx_sr     <= load_src;
          bit_cnt   <= '0;
          o_miso    <= i_lsbfe ? load_src[0] : load_src[DATA_W-1];
          o_miso_oe <= 1'b1;
        end
        ST_SHIFT: begin
          if (abort) begin
            bit_cnt   <= '0;
            o_miso    <= 1'b0;
            o_miso_oe <= 1'b0;
          end else begin
            if (sample_edge) begin
              rx_sr   <= lsbfe_q ? {mosi_s, rx_sr[DATA_W-1:1]}
                                 : {rx_sr[DATA_W-2:0], mosi_s};
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
            // A shift edge before any sample belongs to the previous frame or presents bit 0
            if (shift_edge && (bit_cnt != '0)) begin
              if (lsbfe_q) begin
                tx_sr  <= tx_sr >> 1;
                o_miso <= tx_sr[1];
              end else begin
                tx_sr  <= tx_sr << 1;
                o_miso <= tx_sr[DATA_W-2];
              end
            end
          end
        end
        ST_DONE: begin
          if (state_d == ST_IDLE) begin
            bit_cnt   <= '0;
            o_miso    <= 1'b0;
            o_miso_oe <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // RX buffer: completed frame commits in DONE, host ack clears valid
  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      o_rx_data  <= '0;
      o_rx_valid <= 1'b0;
    end else if (state_q == ST_DONE) begin
`ifdef SPI_SLV_OVR_EN
      if (!o_rx_valid || i_rx_ack) begin
        o_rx_data  <= rx_sr;
        o_rx_valid <= 1'b1;
      end
`else
      o_rx_data  <= rx_sr;
      o_rx_valid <= 1'b1;
`endif
    end else if (i_rx_ack) begin
      o_rx_valid <= 1'b0;
    end
  end

`ifdef SPI_SLV_OVR_EN
  // Sticky overrun: a frame completing onto an unacknowledged byte; set beats clear
  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      o_ovr <= 1'b0;
    end else if ((state_q == ST_DONE) && o_rx_valid && !i_rx_ack) begin
      o_ovr <= 1'b1;
    end else if (i_ovr_clr) begin
      o_ovr <= 1'b0;
    end
  end
`endif

  // Busy mirrors the SHIFT state, registered
  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      o_busy <= 1'b0;
    end else begin
      o_busy <= (state_d == ST_SHIFT);
    end
  end

endmodule

// File: tb/tb_spi_slave_sync.sv
// Directed bench for spi_slave_sync acting as the SPI master and host.
module tb_spi_slave_sync;

  localparam int unsigned HALF = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       spe;
  logic       cpol;
  logic       cpha;
  logic       lsbfe;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic       busy;
  logic       sck;
  logic       ss_n;
  logic       mosi;
  logic       miso;
  logic       miso_oe;
`ifdef SPI_SLV_OVR_EN
  logic       ovr;
  logic       ovr_clr;
`endif

  int         errors;
  int         checks;
  logic [7:0] got;

  spi_slave_sync dut (
    .i_sys_clk (clk),
    .i_sys_rst (rst),
    .i_spe     (spe),
    .i_cpol    (cpol),
    .i_cpha    (cpha),
    .i_lsbfe   (lsbfe),
    .i_tx_data (tx_data),
    .i_tx_valid(tx_valid),
    .o_tx_ready(tx_ready),
    .o_rx_data (rx_data),
    .o_rx_valid(rx_valid),
    .i_rx_ack  (rx_ack),
    .o_busy    (busy),
`ifdef SPI_SLV_OVR_EN
    .o_ovr     (ovr),
    .i_ovr_clr (ovr_clr),
`endif
    .i_sck     (sck),
    .i_ss_n    (ss_n),
    .i_mosi    (mosi),
    .o_miso    (miso),
    .o_miso_oe (miso_oe)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=0x%h expected=0x%h", tag, obs, exp_v);
    end
  endtask

  task automatic half();
    repeat (HALF) @(negedge clk);
  endtask

  task automatic wr_tx(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic pulse_ack();
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
  endtask

  task automatic sel();
    ss_n = 1'b0;
    half();
  endtask

  task automatic desel();
    ss_n = 1'b1;
    half();
  endtask

  // Master side of one frame in the current mode; MISO captured at the sample edge
  task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    logic [2:0] idx;
    mi = 8'h00;
    for (int k = 0; k < nbits; k++) begin
      idx = lsbfe ? 3'(k) : 3'(7 - k);
      if (!cpha) begin
        mosi = mo[idx];
        half();
        mi[idx] = miso;
        sck = ~cpol;
        half();
        sck = cpol;
      end else begin
        sck  = ~cpol;
        mosi = mo[idx];
        half();
        mi[idx] = miso;
        sck = cpol;
        half();
      end
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    errors   = 0;
    checks   = 0;
    rst      = 1'b1;
    spe      = 1'b1;
    cpol     = 1'b0;
    cpha     = 1'b0;
    lsbfe    = 1'b0;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    rx_ack   = 1'b0;
    sck      = 1'b0;
    ss_n     = 1'b1;
    mosi     = 1'b0;
`ifdef SPI_SLV_OVR_EN
    ovr_clr  = 1'b0;
`endif
    repeat (3) @(negedge clk);

    // Reset values
    chk1("rst_tx_ready", tx_ready, 1'b1);
    chk8("rst_rx_data", rx_data, 8'h00);
    chk1("rst_rx_valid", rx_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_miso", miso, 1'b0);
    chk1("rst_miso_oe", miso_oe, 1'b0);
    rst = 1'b0;
    half();

    // Mode 0, MSB first: TX A5, MOSI 3C
    wr_tx(8'hA5);
    chk1("m0_tx_full", tx_ready, 1'b0);
    sel();
    chk1("m0_oe", miso_oe, 1'b1);
    chk1("m0_busy", busy, 1'b1);
    chk1("m0_tx_ready_after_load", tx_ready, 1'b1);
    xfer(8'h3C, 8, got);
    chk8("m0_miso", got, 8'hA5);
    chk8("m0_rx_data", rx_data, 8'h3C);
    chk1("m0_rx_valid", rx_valid, 1'b1);
    desel();
    chk1("m0_oe_off", miso_oe, 1'b0);
    pulse_ack();
    chk1("m0_ack", rx_valid, 1'b0);

    // Modes 1..3, LSB first: TX 81, MOSI 42
    for (int m = 1; m < 4; m++) begin
      cpol  = m[1];
      cpha  = m[0];
      lsbfe = 1'b1;
      sck   = cpol;
      half();
      wr_tx(8'h81);
      sel();
      xfer(8'h42, 8, got);
      chk8($sformatf("m%0d_miso", m), got, 8'h81);
      chk8($sformatf("m%0d_rx_data", m), rx_data, 8'h42);
      chk1($sformatf("m%0d_rx_valid", m), rx_valid, 1'b1);
      desel();
      pulse_ack();
    end

    // Back-to-back frames under one select, mode 0 MSB first
    cpol  = 1'b0;
    cpha  = 1'b0;
    lsbfe = 1'b0;
    sck   = 1'b0;
    half();
    wr_tx(8'h11);
    sel();
    wr_tx(8'h22);
    chk1("b2b_tx_full", tx_ready, 1'b0);
    xfer(8'h5A, 8, got);
    chk8("b2b_miso1", got, 8'h11);
    chk8("b2b_rx1", rx_data, 8'h5A);
    chk1("b2b_valid1", rx_valid, 1'b1);
    pulse_ack();
    chk1("b2b_ack1", rx_valid, 1'b0);
    xfer(8'hC3, 8, got);
    chk8("b2b_miso2", got, 8'h22);
    chk8("b2b_rx2", rx_data, 8'hC3);
    chk1("b2b_valid2", rx_valid, 1'b1);
    desel();
    pulse_ack();

    // Empty TX buffer returns the underrun byte
    sel();
    chk1("empty_tx_ready", tx_ready, 1'b1);
    xfer(8'h00, 8, got);
    chk8("empty_miso", got, 8'hFF);
    chk8("empty_rx", rx_data, 8'h00);
    desel();
    pulse_ack();

    // Abort after 4 bits of F0
    sel();
    xfer(8'hF0, 4, got);
    chk8("abort_partial_miso", got, 8'hF0);
    ss_n = 1'b1;
    repeat (4) @(negedge clk);
    chk1("abort_oe", miso_oe, 1'b0);
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_valid", rx_valid, 1'b0);
    half();
    chk1("abort_valid_later", rx_valid, 1'b0);
    wr_tx(8'h96);
    sel();
    xfer(8'h69, 8, got);
    chk8("post_abort_miso", got, 8'h96);
    chk8("post_abort_rx", rx_data, 8'h69);
    chk1("post_abort_valid", rx_valid, 1'b1);
    desel();

    // Async reset in the middle of a frame
    wr_tx(8'h3C);
    sel();
    xfer(8'hF0, 4, got);
    repeat (5) @(negedge clk);
    chk1("pre_rst_miso", miso, 1'b1);
    chk1("pre_rst_oe", miso_oe, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk1("arst_tx_ready", tx_ready, 1'b1);
    chk8("arst_rx_data", rx_data, 8'h00);
    chk1("arst_rx_valid", rx_valid, 1'b0);
    chk1("arst_busy", busy, 1'b0);
    chk1("arst_miso", miso, 1'b0);
    chk1("arst_miso_oe", miso_oe, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    half();
    chk1("rearm_busy", busy, 1'b0);
    chk1("rearm_oe", miso_oe, 1'b0);
    ss_n = 1'b1;
    sck  = 1'b0;
    half();

    // Two frames without ack
    sel();
    xfer(8'h01, 8, got);
    desel();
    sel();
    xfer(8'h02, 8, got);
    desel();
`ifdef SPI_SLV_OVR_EN
    chk1("ovr_set", ovr, 1'b1);
    chk8("ovr_rx_kept", rx_data, 8'h01);
    chk1("ovr_valid", rx_valid, 1'b1);
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    chk1("ovr_clr", ovr, 1'b0);
`else
    chk8("overwrite_rx", rx_data, 8'h02);
    chk1("overwrite_valid", rx_valid, 1'b1);
`endif
    pulse_ack();
    chk1("final_ack", rx_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
